oam_scanner: RTL and testbench
==============================

OAM_SCANNER -- requirements
Module: oam_scanner

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock; the only clock.
- reset  in  1  reset; asynchronous, active-high.
- slow_clk_en  in  1  dot-rate enable; all state advances only on clk edges with slow_clk_en=1.
- mode  in  2  PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 draw).
- ly  in  8  current line, 0..153.
- sp_8x16  in  1  sprite height select: 1 = 16 lines, 0 = 8 lines.
- oam_scan_addr  out  8  OAM byte address.
- oam_rdata  in  8  OAM read data, valid one enabled cycle after its address.
- oam_scan_active  out  1  scanner owns the OAM port.
- oam_scan_sp_num  out  6  OAM index of the selected sprite.
- oam_scan_fine_y  out  4  row within the sprite, 0..15.
- line_sp_list_write  out  1  one-cycle pulse; pushes oam_scan_sp_num and oam_scan_fine_y to the sprite fetcher.

Function
REQ-002 The block SHALL have three states: IDLE, SCAN and DONE.
REQ-003 IDLE->SCAN SHALL occur on the first enabled edge where mode==2 and the registered previous mode !=2. On entry, sp_idx, phase and found are cleared.
REQ-004 In SCAN, phase SHALL toggle on every enabled edge. sp_idx (0..39) SHALL increment when phase goes 1->0. A full scan takes 80 enabled cycles.
REQ-005 After the phase-1 evaluation of sp_idx=39, the state SHALL go SCAN->DONE.
REQ-006 DONE->IDLE SHALL occur when mode!=2. From SCAN, mode!=2 SHALL force IDLE and abort the scan, with no further writes.
REQ-007 oam_scan_addr SHALL equal {sp_idx,2'b00} (the Y byte) combinationally in SCAN, and 8'h00 otherwise.
REQ-008 oam_scan_active SHALL be 1 exactly in SCAN.
REQ-009 On each phase-1 edge, the block SHALL compute diff = ly + 8'd16 - oam_rdata, modulo 256.
- hit = (diff < (sp_8x16 ? 16 : 8)) and (found < 10).
REQ-010 On a hit, the block SHALL register line_sp_list_write=1, oam_scan_sp_num=sp_idx and oam_scan_fine_y=diff[3:0], and SHALL increment found.
- With no hit, line_sp_list_write SHALL be registered 0.
REQ-011 line_sp_list_write SHALL be cleared on the next enabled edge, so it is high for exactly one enabled cycle. oam_scan_sp_num and oam_scan_fine_y SHALL hold until the next hit.
REQ-012 found SHALL saturate at 10. Sprites after the 10th hit are ignored, in OAM-index order.
REQ-013 A write from sprite 39 SHALL still be issued if mode has already changed to 3 on that edge.
REQ-014 The Y boundaries SHALL behave as follows:
- Y=0 never hits.
- Y>=160 never hits for ly<=143.
- Y=16 hits at ly 0..7 (8x8) or ly 0..15 (8x16).
REQ-015 With slow_clk_en=0, all state and outputs SHALL hold.

Reset
REQ-016 Asserting reset SHALL asynchronously force:
- state IDLE
- sp_idx=0, phase=0, found=0
- previous mode=0
- line_sp_list_write=0, oam_scan_sp_num=0, oam_scan_fine_y=0
- oam_scan_active=0, oam_scan_addr=0
REQ-017 Reset deasserted during mode 2 SHALL NOT start a scan until the next entry into mode 2.

Configuration
REQ-018 Macro OAM_SCAN_STATUS_EN, when defined, SHALL add two outputs:
- scan_count  out  4  equals found; cleared on scan start.
- scan_overflow  out  1  set when a sprite would have hit with found==10; cleared on scan start.
- Both outputs reset to 0.
REQ-019 Without OAM_SCAN_STATUS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- ly=0, 8x8, sprite 5 Y=16, others Y=0 -> one write, sp_num=5, fine_y=0, on the enabled edge after the phase-1 evaluation of sp_idx=5; 80-cycle scan ends in DONE.
- ly=20, 8x16, sprite 3 Y=10 -> no write (diff=26); sprite 3 Y=30 -> write, fine_y=6.
- ly=40, 8x8, all 40 sprites Y=50 -> exactly 10 writes, sp_num 0..9; with OAM_SCAN_STATUS_EN, scan_count=10 and scan_overflow=1.
- Sprites 38 and 39 hit, mode 2->3 right after cycle 80 -> both writes issued, and the sprite-39 write is seen in mode 3.
- Mode 2->0 at cycle 30 -> state IDLE, no further writes, oam_scan_active=0.
- Reset asserted mid-scan with slow_clk_en=0 -> all outputs 0 immediately.

Source files
------------

// File: rtl/oam_scanner.sv
// oam_scanner: walks the 40-entry sprite attribute table during the OAM-scan
// mode and pushes up to 10 sprites that intersect the current line to the
// sprite fetcher.
//
// Each sprite takes two dot-rate cycles:
//   - In phase 0 its Y byte address is presented.
//   - In phase 1 the Y byte arrives on oam_rdata and is compared against the
//     current line.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   slow_clk_en          dot-rate enable; all state advances only when high
//   mode, ly, sp_8x16    PPU mode, current line, sprite height select
//   oam_scan_addr        OAM byte address (Y byte of the current sprite)
//   oam_rdata            OAM read data, one enabled cycle after its address
//   oam_scan_active      scanner owns the OAM port
//   oam_scan_sp_num      OAM index of the last selected sprite
//   oam_scan_fine_y      row within the last selected sprite
//   line_sp_list_write   one-enabled-cycle push strobe to the sprite fetcher
//
// Optional feature (macro OAM_SCAN_STATUS_EN) adds two outputs:
//   scan_count           number of sprites selected in the current scan
//   scan_overflow        a sprite intersected the line after 10 were taken
module oam_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk_en,
  input  logic [1:0] mode,
  input  logic [7:0] ly,
  input  logic       sp_8x16,
  output logic [7:0] oam_scan_addr,
  input  logic [7:0] oam_rdata,
  output logic       oam_scan_active,
  output logic [5:0] oam_scan_sp_num,
  output logic [3:0] oam_scan_fine_y,
  output logic       line_sp_list_write
`ifdef OAM_SCAN_STATUS_EN
  ,
  output logic [3:0] scan_count,
  output logic       scan_overflow
`endif
);

  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [5:0] LAST_SPRITE = 6'd39;
  localparam logic [3:0] MAX_FOUND   = 4'd10;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_nxt;
  logic [5:0] sp_idx;
  logic       phase;
  logic [3:0] found;
  logic [1:0] prev_mode;
  // Cleared by reset and set once a non-OAM mode is seen, so that a reset
  // released in the middle of mode 2 waits for the next genuine mode-2 entry.
  logic       mode_armed;

  logic       start;
  logic       eval;
  logic [7:0] diff;
  logic       in_range;
  logic       hit;
`ifdef OAM_SCAN_STATUS_EN
  logic       over;
`endif

  // Line offset of the current line relative to the sprite top. The OAM Y
  // value is biased by 16, and the subtraction wraps modulo 256.
  function automatic logic [7:0] row_offset(input logic [7:0] line,
                                            input logic [7:0] y);
    return line + 8'd16 - y;
  endfunction

  function automatic logic row_in_sprite(input logic [7:0] offs,
                                         input logic       tall);
    return tall ? (offs < 8'd16) : (offs < 8'd8);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (slow_clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    eval      = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_OAM && prev_mode != MODE_OAM && mode_armed) begin
          state_nxt = SCAN;
          start     = 1'b1;
        end
      end
      SCAN: begin
        // The final evaluation (sprite 39) completes even if the mode has
        // already moved on, so the last sprite is never lost at the boundary.
        if (phase && sp_idx == LAST_SPRITE) begin
          state_nxt = DONE;
          eval      = 1'b1;
        end else if (mode != MODE_OAM) begin
          state_nxt = IDLE;
        end else begin
          eval = phase;
        end
      end
      DONE: begin
        if (mode != MODE_OAM) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign diff     = row_offset(ly, oam_rdata);
  assign in_range = row_in_sprite(diff, sp_8x16);
  assign hit      = eval && in_range && (found < MAX_FOUND);
`ifdef OAM_SCAN_STATUS_EN
  assign over     = eval && in_range && (found == MAX_FOUND);
`endif

  assign oam_scan_active = (state == SCAN);
  assign oam_scan_addr   = (state == SCAN) ? {sp_idx, 2'b00} : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_idx             <= 6'd0;
      phase              <= 1'b0;
      found              <= 4'd0;
      prev_mode          <= 2'd0;
      mode_armed         <= 1'b0;
      line_sp_list_write <= 1'b0;
      oam_scan_sp_num    <= 6'd0;
      oam_scan_fine_y    <= 4'd0;
    end else if (slow_clk_en) begin
      prev_mode          <= mode;
      line_sp_list_write <= hit;
      if (mode != MODE_OAM) begin
        mode_armed <= 1'b1;
      end
      if (start) begin
        sp_idx <= 6'd0;
        phase  <= 1'b0;
        found  <= 4'd0;
      end else if (state == SCAN) begin
        phase <= ~phase;
        if (phase && sp_idx != LAST_SPRITE) begin
          sp_idx <= sp_idx + 6'd1;
        end
      end
      if (hit) begin
        oam_scan_sp_num <= sp_idx;
        oam_scan_fine_y <= diff[3:0];
        found           <= found + 4'd1;
      end
    end
  end

`ifdef OAM_SCAN_STATUS_EN
  assign scan_count = found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_overflow <= 1'b0;
    end else if (slow_clk_en) begin
      if (start) begin
        scan_overflow <= 1'b0;
      end else if (over) begin
        scan_overflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oam_scanner.sv
module tb_oam_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       slow_clk_en;
  logic [1:0] mode;
  logic [7:0] ly;
  logic       sp_8x16;
  logic [7:0] oam_scan_addr;
  logic [7:0] oam_rdata;
  logic       oam_scan_active;
  logic [5:0] oam_scan_sp_num;
  logic [3:0] oam_scan_fine_y;
  logic       line_sp_list_write;
`ifdef OAM_SCAN_STATUS_EN
  logic [3:0] scan_count;
  logic       scan_overflow;
`endif

  logic [7:0] oam_mem [256];
  int         n_tests = 0;
  int         n_fail  = 0;
  // Last sprite pushed to the fetcher, as predicted by the reference model.
  logic [5:0] m_num;
  logic [3:0] m_fy;

  oam_scanner dut (
    .clk                (clk),
    .reset              (reset),
    .slow_clk_en        (slow_clk_en),
    .mode               (mode),
    .ly                 (ly),
    .sp_8x16            (sp_8x16),
    .oam_scan_addr      (oam_scan_addr),
    .oam_rdata          (oam_rdata),
    .oam_scan_active    (oam_scan_active),
    .oam_scan_sp_num    (oam_scan_sp_num),
    .oam_scan_fine_y    (oam_scan_fine_y),
    .line_sp_list_write (line_sp_list_write)
`ifdef OAM_SCAN_STATUS_EN
    ,
    .scan_count         (scan_count),
    .scan_overflow      (scan_overflow)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous OAM: data for an address appears one enabled cycle later.
  always @(posedge clk) begin
    if (slow_clk_en) oam_rdata <= oam_mem[oam_scan_addr];
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick(input logic en);
    slow_clk_en = en;
    @(posedge clk);
    #1;
  endtask

  // Random bytes everywhere, with every sprite's Y byte set to y.
  task automatic fill_oam(input logic [7:0] y);
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'($urandom);
    for (int s = 0; s < 40; s++) oam_mem[4*s] = y;
  endtask

  // One scan with the reference model. abort_at: enabled edge (counted from
  // the scan-start edge = 0) at which mode becomes abort_mode; 0 = never.
  // to3: mode becomes 3 right after edge 80. rand_en: random idle cycles.
  task automatic run_scan(input string name, input logic [7:0] ly_v,
                          input logic tall, input int abort_at,
                          input logic [1:0] abort_mode, input bit to3,
                          input bit rand_en);
    bit         hit [40];
    logic [3:0] hfy [40];
    int         found   = 0;
    int         exp_cnt = 0;
    int         seen    = 0;
    bit         ovf     = 0;
    int         h;
    logic [7:0] d;
    logic [19:0] got, want, snap;
    bit         act, ew;
    h = tall ? 16 : 8;
    // Model: sprites in index order, first ten intersecting ones selected;
    // evaluations at or after an abort are lost, except the final sprite.
    for (int s = 0; s < 40; s++) begin
      hit[s] = 0;
      hfy[s] = 4'd0;
      d = ly_v + 8'd16 - oam_mem[4*s];
      if (abort_at == 0 || (2*s + 2) < abort_at || (s == 39 && abort_at == 80)) begin
        if (int'(d) < h) begin
          if (found < 10) begin
            hit[s] = 1;
            hfy[s] = d[3:0];
            found++;
            exp_cnt++;
          end else begin
            ovf = 1;
          end
        end
      end
    end

    mode = 2'd0; ly = ly_v; sp_8x16 = tall;
    tick(1);
    tick(1);
    mode = 2'd2;
    tick(1);
    n_tests++;
    if (oam_scan_active !== 1'b1 || oam_scan_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL %s start: active=%b addr=%h, want active=1 addr=00",
               name, oam_scan_active, oam_scan_addr);
    end

    for (int k = 1; k <= 84; k++) begin
      if (rand_en) begin
        int gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          snap = {line_sp_list_write, oam_scan_active, oam_scan_addr,
                  oam_scan_sp_num, oam_scan_fine_y};
          tick(0);
          got = {line_sp_list_write, oam_scan_active, oam_scan_addr,
                 oam_scan_sp_num, oam_scan_fine_y};
          n_tests++;
          if (got !== snap) begin
            n_fail++;
            $display("FAIL %s hold before edge %0d: got %h, want %h", name, k, got, snap);
          end
        end
      end
      if (abort_at != 0 && k == abort_at) mode = abort_mode;
      if (to3 && k == 81) mode = 2'd3;
      tick(1);
      act = !(abort_at != 0 && k >= abort_at) && k < 80;
      ew  = 0;
      if (k % 2 == 0 && k >= 2 && k <= 80 && hit[(k-2)/2]) begin
        ew    = 1;
        m_num = 6'((k-2)/2);
        m_fy  = hfy[(k-2)/2];
      end
      want = {ew, act, act ? {6'(k/2), 2'b00} : 8'h00, m_num, m_fy};
      got  = {line_sp_list_write, oam_scan_active, oam_scan_addr,
              oam_scan_sp_num, oam_scan_fine_y};
      if (line_sp_list_write === 1'b1) seen++;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s edge %0d: got w=%b act=%b addr=%h num=%0d fy=%0d, want w=%b act=%b addr=%h num=%0d fy=%0d",
                 name, k, got[19], got[18], got[17:10], got[9:4], got[3:0],
                 want[19], want[18], want[17:10], want[9:4], want[3:0]);
      end
    end

    n_tests++;
    if (seen != exp_cnt) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, want %0d", name, seen, exp_cnt);
    end
`ifdef OAM_SCAN_STATUS_EN
    n_tests++;
    if (scan_count !== 4'(found) || scan_overflow !== ovf) begin
      n_fail++;
      $display("FAIL %s status: got count=%0d ovf=%b, want count=%0d ovf=%b",
               name, scan_count, scan_overflow, found, ovf);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'd2; ly = 8'd0; sp_8x16 = 1'b0; slow_clk_en = 1'b0;
    fill_oam(8'd0);
    m_num = 6'd0; m_fy = 4'd0;
    tick(1);
    tick(1);
    n_tests++;
    if ({line_sp_list_write, oam_scan_active, oam_scan_addr, oam_scan_sp_num,
         oam_scan_fine_y} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: w=%b act=%b addr=%h num=%0d fy=%0d, want all 0",
               line_sp_list_write, oam_scan_active, oam_scan_addr,
               oam_scan_sp_num, oam_scan_fine_y);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_tests++;
      if (oam_scan_active !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_in_mode2 cycle %0d: active=%b, want 0", i, oam_scan_active);
      end
    end
    mode = 2'd0;
    tick(1);
  endtask

  task automatic test_single_hit();
    fill_oam(8'd0);
    oam_mem[20] = 8'd16;
    run_scan("single_hit", 8'd0, 1'b0, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_tall();
    fill_oam(8'd0);
    oam_mem[12] = 8'd10;
    run_scan("tall_miss", 8'd20, 1'b1, 0, 2'd0, 1'b0, 1'b0);
    oam_mem[12] = 8'd30;
    run_scan("tall_hit", 8'd20, 1'b1, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    fill_oam(8'd50);
    run_scan("overflow", 8'd40, 1'b0, 0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_end_mode3();
    fill_oam(8'd0);
    oam_mem[152] = 8'd16;
    oam_mem[156] = 8'd16;
    run_scan("end_mode3", 8'd3, 1'b0, 0, 2'd0, 1'b1, 1'b0);
    run_scan("last_edge_mode3", 8'd3, 1'b0, 80, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    fill_oam(8'd0);
    oam_mem[8]  = 8'd16;
    oam_mem[40] = 8'd16;
    oam_mem[56] = 8'd16;
    oam_mem[80] = 8'd16;
    run_scan("abort", 8'd0, 1'b0, 30, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_boundaries();
    logic [7:0] l;
    fill_oam(8'd0);
    l = 8'($urandom_range(0, 153));
    run_scan("y0_never", l, 1'b1, 0, 2'd0, 1'b0, 1'b0);
    fill_oam(8'd0);
    for (int s = 0; s < 40; s++) oam_mem[4*s] = 8'($urandom_range(160, 255));
    l = 8'($urandom_range(0, 143));
    run_scan("y_high_never", l, 1'b1, 0, 2'd0, 1'b0, 1'b0);
    fill_oam(8'd0);
    oam_mem[0] = 8'd16;
    run_scan("y16_ly7_short", 8'd7, 1'b0, 0, 2'd0, 1'b0, 1'b0);
    run_scan("y16_ly8_short", 8'd8, 1'b0, 0, 2'd0, 1'b0, 1'b0);
    run_scan("y16_ly15_tall", 8'd15, 1'b1, 0, 2'd0, 1'b0, 1'b0);
    run_scan("y16_ly16_tall", 8'd16, 1'b1, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] l;
    logic       t;
    int         ab;
    for (int r = 0; r < 6; r++) begin
      l = 8'($urandom_range(0, 153));
      t = 1'($urandom_range(0, 1));
      fill_oam(8'd0);
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(0, 1) == 1)
          oam_mem[4*s] = 8'(int'(l) + 16 - int'($urandom_range(0, 20)));
        else
          oam_mem[4*s] = 8'($urandom);
      end
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 79)) : 0;
      run_scan($sformatf("random%0d", r), l, t, ab, 2'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_midscan();
    fill_oam(8'd0);
    oam_mem[20] = 8'd16;
    mode = 2'd0; ly = 8'd0; sp_8x16 = 1'b0;
    tick(1);
    tick(1);
    mode = 2'd2;
    tick(1);
    repeat (12) tick(1);
    n_tests++;
    if (line_sp_list_write !== 1'b1 || oam_scan_sp_num !== 6'd5) begin
      n_fail++;
      $display("FAIL midscan_pre: w=%b num=%0d, want w=1 num=5",
               line_sp_list_write, oam_scan_sp_num);
    end
    slow_clk_en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({line_sp_list_write, oam_scan_active, oam_scan_addr, oam_scan_sp_num,
         oam_scan_fine_y} !== 20'h0) begin
      n_fail++;
      $display("FAIL midscan_reset: w=%b act=%b addr=%h num=%0d fy=%0d, want all 0",
               line_sp_list_write, oam_scan_active, oam_scan_addr,
               oam_scan_sp_num, oam_scan_fine_y);
    end
`ifdef OAM_SCAN_STATUS_EN
    n_tests++;
    if (scan_count !== 4'd0 || scan_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_reset_status: count=%0d ovf=%b, want 0 0",
               scan_count, scan_overflow);
    end
`endif
    m_num = 6'd0; m_fy = 4'd0;
    tick(0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_tests++;
      if (oam_scan_active !== 1'b0 || line_sp_list_write !== 1'b0) begin
        n_fail++;
        $display("FAIL midscan_no_restart cycle %0d: act=%b w=%b, want 0 0",
                 i, oam_scan_active, line_sp_list_write);
      end
    end
    // A fresh mode-2 entry after reset must start a normal scan.
    run_scan("after_reset", 8'd0, 1'b0, 0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_tall();
    test_overflow();
    test_end_mode3();
    test_abort();
    test_boundaries();
    test_random();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
